pep_ks_cmd_seq: RTL

//  Upstream feeder of the KS control stage. Takes PBS batch requests (wp/rp window) and splits each batch

---
 rtl/pep_ks_cmd_seq_pkg.sv | 22 ++
 rtl/pep_ks_cmd_credit.sv | 25 ++
 rtl/pep_ks_cmd_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/pep_ks_cmd_seq_pkg.sv
// Shared KS package: sequencer configuration, the per-column command layout and the sequencer states.
package pep_ks_cmd_seq_pkg;

  localparam int KS_BLOCK_COL_NB = 4;
  localparam int LBX             = 2;
  localparam int PTR_W           = 8;
  localparam int CRED_W          = 2;
  localparam int KS_LOOP_W       = $clog2(KS_BLOCK_COL_NB * LBX);
  localparam int KS_CMD_W        = 2 * PTR_W + KS_LOOP_W;

  typedef struct packed {
    logic [PTR_W-1:0]     wp;
    logic [PTR_W-1:0]     rp;
    logic [KS_LOOP_W-1:0] ks_loop;
  } ks_seq_cmd_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } ks_seq_state_e;

endpackage

// File: rtl/pep_ks_cmd_credit.sv
// Enquiry credit counter: +1 per enquiry, -1 per issued command, saturating at the all-ones value.
module pep_ks_cmd_credit #(
  parameter int CRED_W = 2
) (
  input  logic              clk,
  input  logic              s_rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [CRED_W-1:0] credit
);

  localparam logic [CRED_W-1:0] CRED_MAX = {CRED_W{1'b1}};

  // NOTE: registers use <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      credit <= '0;
    end else if (inc && !dec && (credit != CRED_MAX)) begin
      credit <= credit + CRED_W'(1);
    end else if (dec && !inc) begin
      credit <= credit - CRED_W'(1);
    end
  end

endmodule

// File: rtl/pep_ks_cmd_seq.sv
// Splits PBS batch requests into per-column KS commands, one per enquiry credit from KS control.
// Optional sticky error flag (credit overflow, empty batch) is built when PEP_KS_CMD_SEQ_ERR_EN is defined.
module pep_ks_cmd_seq
  import pep_ks_cmd_seq_pkg::*;
(
  input  logic                clk,
  input  logic                s_rst_n,
  input  logic                reset_cache,
  input  logic [PTR_W-1:0]    req_wp,
  input  logic [PTR_W-1:0]    req_rp,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic                ks_seq_cmd_enquiry,
  output logic [KS_CMD_W-1:0] seq_ks_cmd,
  output logic                seq_ks_cmd_avail,
  output logic                batch_done,
  output logic                cmd_seq_error
);

  localparam int               COL_W    = $clog2(KS_BLOCK_COL_NB);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(KS_BLOCK_COL_NB - 1);

  ks_seq_state_e     state_q, state_d;
  logic              rst_q;
  logic [PTR_W-1:0]  wp_q, rp_q;
  logic [COL_W-1:0]  col_q;
  logic [CRED_W-1:0] credit;
  logic              issue, accept, last_col;
  ks_seq_cmd_t       cmd_q;

  assign last_col   = (col_q == LAST_COL);
  assign seq_ks_cmd = cmd_q;

  always_ff @(posedge clk) begin
    if (!s_rst_n) rst_q <= 1'b0;
    else          rst_q <= reset_cache;
  end

  pep_ks_cmd_credit #(
    .CRED_W (CRED_W)
  ) u_credit (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .inc     (ks_seq_cmd_enquiry),
    .dec     (issue),
    .credit  (credit)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    req_rdy = 1'b0;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        req_rdy = 1'b1;
        accept  = req_vld && !rst_q;
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        // Only registered credit counts; a same-cycle enquiry is seen next cycle.
        issue = (credit != '0) && !rst_q;
        if (issue && last_col) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_q) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wp_q <= req_wp;
        rp_q <= req_rp;
      end
      if (rst_q || accept) col_q <= '0;
      else if (issue)      col_q <= last_col ? '0 : col_q + COL_W'(1);
    end
  end

  // Command registers hold their value between avail pulses.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      cmd_q            <= '0;
      seq_ks_cmd_avail <= 1'b0;
      batch_done       <= 1'b0;
    end else begin
      seq_ks_cmd_avail <= issue;
      batch_done       <= issue && last_col;
      if (issue) begin
        cmd_q.wp      <= wp_q;
        cmd_q.rp      <= rp_q;
        cmd_q.ks_loop <= KS_LOOP_W'(int'(col_q) * LBX);
      end
    end
  end

`ifdef PEP_KS_CMD_SEQ_ERR_EN
  logic cred_ovf, empty_req;

  assign cred_ovf  = ks_seq_cmd_enquiry && !issue && (credit == {CRED_W{1'b1}});
  assign empty_req = accept && (req_wp == req_rp);

  always_ff @(posedge clk) begin
    if (!s_rst_n)                   cmd_seq_error <= 1'b0;
    else if (cred_ovf || empty_req) cmd_seq_error <= 1'b1;
  end
`else
  assign cmd_seq_error = 1'b0;
`endif

endmodule
